// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises and debounces raw button pins, emits one-cycle
// press pulses (with auto-repeat on selected buttons) and keeps a sticky
// pending flag per button until the consumer acknowledges it.
module btn_conditioner #(
  parameter int                 NUM_BTN         = 5,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter int                 CNT_W           = 18,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_PERIOD   = 5000000,
  parameter int                 REP_W           = 25,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(5'b00011)
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_pending,
  input  logic [NUM_BTN-1:0] pending_ack
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] s1_q;
  logic [NUM_BTN-1:0] s_q;

  // Two-flop synchroniser; the raw pins feed nothing else.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s_q  <= '0;
    end else begin
      s1_q <= btn_raw;
      s_q  <= s1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             pend_q, pend_d;
      logic             rep_fire;

      // Debounce: level follows s only after it has differed for DEBOUNCE_CYCLES edges.
      always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (s_q[gi] == level_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          level_d  = s_q[gi];
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end

      if (REPEAT_MASK[gi]) begin : g_rep
        logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
        logic             phase_q, phase_d;
        logic             fire;

        // Repeat timer runs only while the level stays high across this edge;
        // a rising edge or a release leaves it cleared in the delay phase.
        always_comb begin
          rep_cnt_d = '0;
          phase_d   = 1'b0;
          fire      = 1'b0;
          if (level_q && level_d) begin
            if ((!phase_q && rep_cnt_q == DELAY_LAST) ||
                ( phase_q && rep_cnt_q == PERIOD_LAST)) begin
              fire    = 1'b1;
              phase_d = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
              phase_d   = phase_q;
            end
          end
        end

        // Repeat counter and phase registers.
        always_ff @(posedge CLK or posedge reset) begin
          if (reset) begin
            rep_cnt_q <= '0;
            phase_q   <= 1'b0;
          end else begin
            rep_cnt_q <= rep_cnt_d;
            phase_q   <= phase_d;
          end
        end

        assign rep_fire = fire;
      end else begin : g_norep
        assign rep_fire = 1'b0;
      end

      // Press on the debounced rising edge or a repeat; set beats ack for pending.
      always_comb begin
        press_d = (level_d & ~level_q) | rep_fire;
        pend_d  = press_q | (pend_q & ~pending_ack[gi]);
      end

      // Per-button state registers; all outputs come straight from flops.
      always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
          db_cnt_q <= '0;
          level_q  <= 1'b0;
          press_q  <= 1'b0;
          pend_q   <= 1'b0;
        end else begin
          db_cnt_q <= db_cnt_d;
          level_q  <= level_d;
          press_q  <= press_d;
          pend_q   <= pend_d;
        end
      end

      assign btn_level[gi]   = level_q;
      assign btn_press[gi]   = press_q;
      assign btn_pending[gi] = pend_q;
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus randomized segments, every cycle
// compared against a window-based reference model of the button conditioner.
module tb_btn_conditioner;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam logic [NB-1:0] RMASK = 5'b00011;
  localparam int HSZ = 16384;

  logic          CLK = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_pending;
  logic [NB-1:0] pending_ack;

  always #5 CLK = ~CLK;

  btn_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_W(3),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REP_W(4), .REPEAT_MASK(RMASK)
  ) dut (
    .CLK(CLK), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_pending(btn_pending), .pending_ack(pending_ack)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: samp[b][k] is the raw value sampled at edge k since reset.
  bit            samp [NB][HSZ];
  int            n;
  logic [NB-1:0] m_level, m_press, m_pend;
  int            rise_edge [NB];

  task automatic model_reset();
    n = 0;
    m_level = '0;
    m_press = '0;
    m_pend  = '0;
    for (int b = 0; b < NB; b++) rise_edge[b] = 0;
  endtask

  // Level flips when the synchronised value (raw from two edges earlier) has
  // disagreed with the level for the last DB edges. Repeats land at
  // rise + RD + k*RP while the level stays high.
  task automatic model_edge();
    logic [NB-1:0] nl, np, npd;
    bit flip;
    bit v;
    int idx;
    int d;
    n++;
    if (n >= HSZ) $fatal(1, "FAIL model_history overflow n=%0d limit=%0d", n, HSZ);
    for (int b = 0; b < NB; b++) samp[b][n] = btn_raw[b];
    for (int b = 0; b < NB; b++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++) begin
        idx = n - 2 - j;
        v = (idx >= 1) ? samp[b][idx] : 1'b0;
        if (v == m_level[b]) flip = 1'b0;
      end
      nl[b] = m_level[b] ^ flip;
      np[b] = 1'b0;
      if (!m_level[b] && nl[b]) begin
        np[b] = 1'b1;
        rise_edge[b] = n;
      end else if (m_level[b] && nl[b] && RMASK[b]) begin
        d = n - rise_edge[b];
        if (d >= RD && ((d - RD) % RP) == 0) np[b] = 1'b1;
      end
      npd[b] = m_press[b] | (m_pend[b] & ~pending_ack[b]);
    end
    m_level = nl;
    m_press = np;
    m_pend  = npd;
  endtask

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1 time unit later.
  task automatic step();
    @(posedge CLK);
    if (reset) model_reset();
    else model_edge();
    #1;
    check("level", btn_level, m_level);
    check("press", btn_press, m_press);
    check("pending", btn_pending, m_pend);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic clear_pending();
    pending_ack = '1;
    step();
    pending_ack = '0;
  endtask

  int t0;
  int first, cnt, fall;
  int plog[$];
  int exp_rep[4] = '{6, 16, 19, 22};
  logic prev_lvl;
  int seg_len;

  initial begin
    reset = 1'b1;
    btn_raw = '0;
    pending_ack = '0;
    model_reset();
    idle(3);
    check("reset_level", btn_level, '0);
    check("reset_pending", btn_pending, '0);
    reset = 1'b0;
    idle(6);
    $display("[TB] reset release done");

    // Clean press on throw: level/press at edge 6, pending from 7, no repeats.
    t0 = n; first = -1; cnt = 0;
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 56; k++) begin
      step();
      if (btn_press[2]) begin
        cnt++;
        if (first < 0) first = n - t0;
      end
      if (k == 5) check("clean_level_e5", btn_level & 5'b00100, 5'b00000);
      if (k == 6) check("clean_level_e6", btn_level & 5'b00100, 5'b00100);
      if (k == 7) check("clean_pend_e7", btn_pending & 5'b00100, 5'b00100);
    end
    check_int("clean_first_press", first, 6);
    check_int("clean_press_count", cnt, 1);
    btn_raw[2] = 1'b0;
    idle(10);
    clear_pending();
    $display("[TB] clean press: first=%0d count=%0d", first, cnt);

    // Bounce on left: 1,0,1,0 then held 1; final stable sample at edge 5.
    t0 = n; first = -1; cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      btn_raw[0] = (k <= 4) ? logic'(k % 2) : 1'b1;
      step();
      if (btn_press[0]) begin
        cnt++;
        if (first < 0) first = n - t0;
      end
    end
    check_int("bounce_first_press", first, 10);
    check_int("bounce_press_count", cnt, 1);
    btn_raw[0] = 1'b0;
    idle(24);
    clear_pending();
    $display("[TB] bounce: first=%0d count=%0d", first, cnt);

    // Auto-repeat on right: pulses at 6,16,19,22; release sampled at 19, level falls at 24.
    t0 = n; fall = -1; plog.delete();
    btn_raw[1] = 1'b1;
    prev_lvl = btn_level[1];
    for (int k = 1; k <= 40; k++) begin
      if (k == 19) btn_raw[1] = 1'b0;
      step();
      if (btn_press[1]) plog.push_back(n - t0);
      if (prev_lvl && !btn_level[1]) fall = n - t0;
      prev_lvl = btn_level[1];
    end
    check_int("repeat_count", plog.size(), 4);
    for (int j = 0; j < 4; j++)
      check_int($sformatf("repeat_edge%0d", j), (j < plog.size()) ? plog[j] : -1, exp_rep[j]);
    check_int("repeat_fall_edge", fall, 24);
    clear_pending();
    $display("[TB] auto-repeat: pulses=%0d fall=%0d", plog.size(), fall);

    // Ack race: ack coinciding with press keeps pending; later acks clear / no-op.
    t0 = n;
    btn_raw[2] = 1'b1;
    idle(6);
    check("race_press_e6", btn_press & 5'b00100, 5'b00100);
    pending_ack[2] = 1'b1;
    step();
    check("race_set_wins", btn_pending & 5'b00100, 5'b00100);
    pending_ack[2] = 1'b0;
    step();
    check("race_still_pending", btn_pending & 5'b00100, 5'b00100);
    pending_ack[2] = 1'b1;
    step();
    check("race_ack_clears", btn_pending & 5'b00100, 5'b00000);
    step();
    check("race_ack_idle", btn_pending & 5'b00100, 5'b00000);
    pending_ack[2] = 1'b0;
    btn_raw[2] = 1'b0;
    idle(10);
    $display("[TB] ack race done");

    // Async reset mid-repeat on left, then re-press after release of reset.
    btn_raw[0] = 1'b1;
    idle(18);
    reset = 1'b1;
    #1;
    model_reset();
    check("amid_rst_level", btn_level, '0);
    check("amid_rst_press", btn_press, '0);
    check("amid_rst_pending", btn_pending, '0);
    #1;
    reset = 1'b0;
    t0 = n; plog.delete();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_press[0]) plog.push_back(n - t0);
    end
    check_int("rst_repress_edge", (plog.size() > 0) ? plog[0] : -1, 6);
    check_int("rst_next_repeat", (plog.size() > 1) ? plog[1] : -1, 16);
    btn_raw[0] = 1'b0;
    idle(10);
    clear_pending();
    $display("[TB] reset mid-repeat: pulses=%0d", plog.size());

    // Independence: left and reset pressed together.
    t0 = n; first = -1; cnt = -1;
    btn_raw = 5'b01001;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (btn_press[0] && first < 0) first = n - t0;
      if (btn_press[3] && cnt < 0) cnt = n - t0;
    end
    check_int("indep_press0", first, 6);
    check_int("indep_press3", cnt, 6);
    check("indep_both_pending", btn_pending & 5'b01001, 5'b01001);
    pending_ack = 5'b01000;
    step();
    pending_ack = '0;
    check("indep_ack3_only", btn_pending & 5'b01001, 5'b00001);
    btn_raw = '0;
    idle(12);
    clear_pending();
    $display("[TB] independence done");

    // Randomized segments: random levels/holds, sparse acks, occasional reset pulses.
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check("rand_reset", btn_level | btn_press | btn_pending, '0);
        #1;
        reset = 1'b0;
      end
      btn_raw = NB'($urandom);
      seg_len = $urandom_range(1, 20);
      for (int k = 0; k < seg_len; k++) begin
        pending_ack = NB'($urandom & $urandom & $urandom);
        step();
      end
      pending_ack = '0;
      $display("[TB] seg %0d raw=%b len=%0d level=%b pending=%b", s, btn_raw, seg_len, btn_level, btn_pending);
    end
    btn_raw = '0;
    idle(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
